// File: rtl/adder_result_buffer_if.sv
// Consumer-side handshake bundle for adder_result_buffer.
// master = the buffer (drives valid/data), slave = the consumer (drives ready).
// Signals:
//   out_valid : head entry available
//   out_ready : consumer accepts the head entry this cycle
//   out_data  : head entry {carry, sum}
interface adder_result_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH:0]   out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/adder_result_buffer.sv
// Result buffer behind the 4-stage pipelined adder: FIFO of {carry,sum} plus issue credit.
// Latency: res_en in cycle N -> out_valid in cycle N+1 (registered write, fall-through read).
// Backpressure: consumer stalls via out_ready; upstream is throttled by issue_ok since the adder cannot stall.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   issue_en         : one pulse per operand pair launched into the adder
//   res_en, res_data : adder output strobe and {carry, sum}
//   issue_ok         : credit, upstream may issue this cycle
//   out_if           : out_valid / out_ready / out_data consumer handshake
//   fill_count       : entries stored
//   inflight_count   : pairs issued but not yet returned
//   err_overflow     : sticky, a result was dropped on a full FIFO
//   err_spurious     : sticky, a result arrived with nothing in flight
//   err_credit       : sticky, issue_en arrived without credit
module adder_result_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_en,
    input  logic                    res_en,
    input  logic [DATA_WIDTH:0]     res_data,
    output logic                    issue_ok,
    adder_result_buffer_if.master   out_if,
    output logic [CNT_W-1:0]        fill_count,
    output logic [CNT_W-1:0]        inflight_count,
    output logic                    err_overflow,
    output logic                    err_spurious,
    output logic                    err_credit
);

    localparam int               W       = DATA_WIDTH + 1;
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [W-1:0]       last_dat;   // last popped word, shown while empty

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               drop;

    assign fifo_full  = (fill_count == DEPTH_C);
    assign fifo_empty = (fill_count == '0);

    assign pop  = !fifo_empty && out_if.out_ready;
    // A full FIFO still accepts a result if the head leaves in the same cycle.
    assign push = res_en && (!fifo_full || pop);
    assign drop = res_en && fifo_full && !pop;

    // Memory array carries no reset; reads are qualified by fill_count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural PTR_W overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fill_count <= fill_count + CNT_W'(1);
                2'b01:   fill_count <= fill_count - CNT_W'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Holding the last popped word keeps out_data stable after the buffer
    // drains, and gives a clean zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dat <= '0;
        end else if (pop) begin
            last_dat <= mem[rd_ptr];
        end
    end

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_empty ? last_dat : mem[rd_ptr];

    // ------------------------------------------------------------------
    // In-flight tracking
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   inflight_nxt;
    logic               spurious_hit;

    always_comb begin
        inflight_nxt = inflight_count;
        spurious_hit = 1'b0;
        if (issue_en && !res_en) begin
            // Saturate: only reachable past DEPTH through a credit violation.
            if (inflight_count != DEPTH_C) begin
                inflight_nxt = inflight_count + CNT_W'(1);
            end
        end else if (!issue_en && res_en) begin
            if (inflight_count != '0) begin
                inflight_nxt = inflight_count - CNT_W'(1);
            end else begin
                spurious_hit = 1'b1;
            end
        end
        // issue_en and res_en together: one leaves, one enters, count holds.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_count <= '0;
        end else begin
            inflight_count <= inflight_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Credit: every issued pair needs a guaranteed slot when it returns.
    // Built from registered counts only, so a pop this cycle is credited
    // next cycle and there is no path from issue_en back to issue_ok.
    // ------------------------------------------------------------------
    logic [CNT_W:0] committed;

    assign committed = {1'b0, fill_count} + {1'b0, inflight_count};
    assign issue_ok  = (committed < (CNT_W + 1)'(DEPTH));

    // ------------------------------------------------------------------
    // Sticky error flags, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
            err_spurious <= 1'b0;
            err_credit   <= 1'b0;
        end else begin
            if (drop) begin
                err_overflow <= 1'b1;
            end
            if (spurious_hit) begin
                err_spurious <= 1'b1;
            end
            if (issue_en && !issue_ok) begin
                err_credit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer: a vector table for the cycle-exact
// sequences, plus hand-written wrap-around streaming and error/reset checks.
module tb_adder_result_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_en;
    logic          res_en;
    logic [64:0]   res_data;
    logic          issue_ok;
    logic [3:0]    fill_count;
    logic [3:0]    inflight_count;
    logic          err_overflow;
    logic          err_spurious;
    logic          err_credit;

    adder_result_buffer_if #(.DATA_WIDTH(64)) ifc ();

    adder_result_buffer #(
        .DATA_WIDTH (64),
        .DEPTH      (8),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_en       (issue_en),
        .res_en         (res_en),
        .res_data       (res_data),
        .issue_ok       (issue_ok),
        .out_if         (ifc),
        .fill_count     (fill_count),
        .inflight_count (inflight_count),
        .err_overflow   (err_overflow),
        .err_spurious   (err_spurious),
        .err_credit     (err_credit)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One table row: inputs applied for one cycle, then expected state after the edge.
    typedef struct {
        logic        iss;
        logic        res;
        logic [64:0] dat;
        logic        rdy;
        logic        ok;
        logic        vld;
        logic [64:0] odat;
        int          fill;
        int          infl;
        logic [2:0]  err;   // {overflow, spurious, credit}
    } vec_t;

    function automatic vec_t mk(input logic iss, input logic res, input logic [64:0] dat,
                                input logic rdy, input logic ok, input logic vld,
                                input logic [64:0] odat, input int fill, input int infl,
                                input logic [2:0] err);
        vec_t v;
        v.iss = iss; v.res = res; v.dat = dat; v.rdy = rdy;
        v.ok = ok; v.vld = vld; v.odat = odat; v.fill = fill; v.infl = infl; v.err = err;
        return v;
    endfunction

    vec_t vq[$];
    vec_t v;

    task automatic idle_inputs();
        issue_en      = 1'b0;
        res_en        = 1'b0;
        res_data      = '0;
        ifc.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic ok, input logic vld,
                             input int fill, input int infl, input logic [2:0] err);
        chk({tag, "_issue_ok"},  65'(issue_ok), 65'(ok));
        chk({tag, "_out_valid"}, 65'(ifc.out_valid), 65'(vld));
        chk({tag, "_fill"},      65'(fill_count), 65'(fill));
        chk({tag, "_inflight"},  65'(inflight_count), 65'(infl));
        chk({tag, "_err"},       65'({err_overflow, err_spurious, err_credit}), 65'(err));
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] big;
        big = 65'h1_0000_0000_0000_0000;

        // ---------------- build the vector table ----------------
        // reset then idle
        vq.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 3'b000));
        // single transaction: issue, 3 idle, result, then popped
        vq.push_back(mk(1, 0, 0, 1,  1, 0, 0, 0, 1, 3'b000));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 1, 3'b000));
        vq.push_back(mk(0, 1, big, 1, 1, 1, big, 1, 0, 3'b000));
        vq.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b000));
        // credit exhaustion: 8 issues, 8 returns (values 1..8), consumer stalled
        for (int k = 1; k <= 8; k++)
            vq.push_back(mk(1, 0, 0, 0,  (k < 8), 0, 0, 0, k, 3'b000));
        for (int k = 1; k <= 8; k++)
            vq.push_back(mk(0, 1, 65'(k), 0,  0, 1, 65'd1, k, 8 - k, 3'b000));
        // one pop: head 1 leaves, credit returns the following cycle
        vq.push_back(mk(0, 0, 0, 1,  1, 1, 65'd2, 7, 0, 3'b000));
        // refill to full: issue one more, result 9 returns
        vq.push_back(mk(1, 0, 0, 0,  0, 1, 65'd2, 7, 1, 3'b000));
        vq.push_back(mk(0, 1, 65'd9, 0, 0, 1, 65'd2, 8, 0, 3'b000));
        // full + push + pop: 2 leaves, 0x55 stored (nothing in flight -> spurious)
        vq.push_back(mk(0, 1, 65'h55, 1, 0, 1, 65'd3, 8, 0, 3'b010));
        // full + push, no pop: dropped
        vq.push_back(mk(0, 1, 65'h55, 0, 0, 1, 65'd3, 8, 0, 3'b110));
        // drain: 3..9 then 0x55 once
        for (int k = 4; k <= 9; k++)
            vq.push_back(mk(0, 0, 0, 1,  1, 1, 65'(k), 12 - k - 1 + 0, 0, 3'b110));
        vq.push_back(mk(0, 0, 0, 1,  1, 1, 65'h55, 1, 0, 3'b110));
        vq.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b110));
        vq.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b110));

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_out_data", ifc.out_data, 65'd0);
        chk_state("rst", 1, 0, 0, 0, 3'b000);

        // ---------------- table ----------------
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            issue_en      = v.iss;
            res_en        = v.res;
            res_data      = v.dat;
            ifc.out_ready = v.rdy;
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), v.ok, v.vld, v.fill, v.infl, v.err);
            if (v.vld)
                chk($sformatf("vec%0d_out_data", i), ifc.out_data, v.odat);
        end

        // ---------------- wrap-around streaming ----------------
        do_reset();
        begin
            int          issued   = 0;
            int          returned = 0;
            int          popped   = 0;
            int          cyc      = 0;
            logic [3:0]  pipe     = '0;   // 4-stage adder latency model
            logic        rdy_t    = 1'b1;
            while (popped < 20 && cyc < 1000) begin
                issue_en = (issued < 20) && issue_ok;
                if (issue_en) issued++;
                res_en   = pipe[3];
                res_data = pipe[3] ? 65'(100 + returned) : '0;
                if (pipe[3]) returned++;
                pipe = {pipe[2:0], issue_en};
                ifc.out_ready = rdy_t;
                rdy_t = !rdy_t;
                if (ifc.out_valid && ifc.out_ready) begin
                    chk($sformatf("wrap_data%0d", popped), ifc.out_data, 65'(100 + popped));
                    popped++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("wrap_count", 65'(popped), 65'd20);
            idle_inputs();
            @(posedge clk);
            #1;
            chk_state("wrap_end", 1, 0, 0, 0, 3'b000);
        end

        // ---------------- error sources ----------------
        res_en   = 1'b1;
        res_data = 65'h77;
        @(posedge clk);
        #1;
        res_en = 1'b0;
        chk_state("spur", 1, 1, 1, 0, 3'b010);
        chk("spur_out_data", ifc.out_data, 65'h77);
        issue_en = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk_state("credit_full", 0, 1, 1, 7, 3'b010);
        @(posedge clk);
        #1;
        chk_state("credit_err", 0, 1, 1, 8, 3'b011);
        @(posedge clk);
        #1;
        chk("credit_sat", 65'(inflight_count), 65'd8);

        // ---------------- asynchronous reset mid-stream ----------------
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("arst", 1, 0, 0, 0, 3'b000);
        chk("arst_out_data", ifc.out_data, 65'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post_rst", 1, 0, 0, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
